// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the shared memory port arbiter.
// The master modport is the arbiter's view; slave is the view of the requesters and memory.
interface mem_port_arbiter_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 16
);
   localparam int unsigned BeWidth = DATA_WIDTH / 8;

   logic                     if_req;
   logic [ADDRESS_WIDTH-1:0] if_addr;
   logic                     if_ack;
   logic [DATA_WIDTH-1:0]    if_rdata;

   logic                     d_req;
   logic                     d_we;
   logic [ADDRESS_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0]    d_wdata;
   logic [BeWidth-1:0]       d_be;
   logic                     d_ack;
   logic [DATA_WIDTH-1:0]    d_rdata;

   logic                     mem_req;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic [BeWidth-1:0]       mem_be;
   logic                     mem_ack;
   logic [DATA_WIDTH-1:0]    mem_rdata;

   logic                     bus_err;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
             bus_err
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
             bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first with a
// fairness streak limit, and aborts accesses the memory fails to acknowledge in time.
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADDRESS_WIDTH   = 16,
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 16
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);
   localparam int unsigned BeWidth = DATA_WIDTH / 8;
   localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
   localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);
   localparam logic [TmoW-1:0]    TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                   state_q, state_d;
   logic                     data_owner_q, data_owner_d;
   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [BeWidth-1:0]       be_q, be_d;
   logic                     err_q, err_d;
   logic [StreakW-1:0]       streak_q, streak_d;
   logic [TmoW-1:0]          tmo_q, tmo_d;
   logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0]    d_rdata_q, d_rdata_d;
   logic                     grant_data;

   // Data wins a tie unless it has already taken MAX_DATA_STREAK grants in a row over a fetch.
   assign grant_data = bus.d_req && !(bus.if_req && (streak_q == StreakMax));

   always_comb begin
      state_d      = state_q;
      data_owner_d = data_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      err_d        = err_q;
      streak_d     = streak_q;
      tmo_d        = tmo_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.d_req || bus.if_req) begin
               state_d = StBusy;
               tmo_d   = '0;
               err_d   = 1'b0;
               if (grant_data) begin
                  data_owner_d = 1'b1;
                  we_d         = bus.d_we;
                  addr_d       = bus.d_addr;
                  wdata_d      = bus.d_wdata;
                  be_d         = bus.d_we ? bus.d_be : '1;
                  if (!bus.if_req) begin
                     streak_d = '0;
                  end else if (streak_q != StreakMax) begin
                     streak_d = streak_q + 1'b1;
                  end
               end else begin
                  data_owner_d = 1'b0;
                  we_d         = 1'b0;
                  addr_d       = bus.if_addr;
                  wdata_d      = '0;
                  be_d         = '1;
                  streak_d     = '0;
               end
            end
         end
         StBusy: begin
            if (bus.mem_ack || (tmo_q == TmoLast)) begin
               state_d = StResp;
               err_d   = !bus.mem_ack;
               if (data_owner_q) begin
                  d_rdata_d = (bus.mem_ack && !we_q) ? bus.mem_rdata : '0;
               end else begin
                  if_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         data_owner_q <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         err_q        <= 1'b0;
         streak_q     <= '0;
         tmo_q        <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         data_owner_q <= data_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         err_q        <= err_d;
         streak_q     <= streak_d;
         tmo_q        <= tmo_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.mem_req   = (state_q == StBusy);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = be_q;
   assign bus.if_ack    = (state_q == StResp) && !data_owner_q;
   assign bus.d_ack     = (state_q == StResp) && data_owner_q;
   assign bus.bus_err   = (state_q == StResp) && err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: requester and memory models drive the interface,
// a monitor pops expected responses on every ack, scenario tasks check timing and grant order.
module tb_mem_port_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned Timeout = 16;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [BW-1:0] be;
      logic [DW-1:0] wdata;
   } op_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [BW-1:0] be;
      logic [DW-1:0] wdata;
      logic          chk_wdata;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   typedef struct {
      logic is_d;
      int   cyc;
   } ack_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic [AW-1:0] if_ops[$];
   op_t           d_ops[$];
   exp_t          if_q[$];
   exp_t          d_q[$];
   ack_t          ack_log[$];

   int            if_req_cyc = 0;
   int            d_req_cyc = 0;
   int            grant_cyc = 0;
   int            mack_cyc = 0;
   logic          mem_en = 1'b1;
   int            mem_delay = 0;
   logic          fixed_en = 1'b0;
   logic [DW-1:0] fixed_val = '0;
   int            stray_cnt = 0;
   op_t           last_grant;
   logic          mreq_prev = 1'b0;

   mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   mem_port_arbiter #(
      .DATA_WIDTH(DW),
      .ADDRESS_WIDTH(AW),
      .MAX_DATA_STREAK(4),
      .TIMEOUT_CYCLES(Timeout)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return fixed_en ? fixed_val : {~a, a};
   endfunction

   // Fetch requester: holds the request until acked, then presents the next one.
   initial begin : if_requester
      exp_t e;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.if_req = 1'b0;
            if_q.delete();
         end else if (bus.if_ack || !bus.if_req) begin
            if (if_ops.size() > 0) begin
               bus.if_addr = if_ops.pop_front();
               bus.if_req  = 1'b1;
               if_req_cyc  = cyc;
               e.addr      = bus.if_addr;
               e.we        = 1'b0;
               e.be        = '1;
               e.wdata     = '0;
               e.chk_wdata = 1'b0;
               e.rdata     = mem_en ? mem_word(bus.if_addr) : '0;
               e.err       = !mem_en;
               if_q.push_back(e);
            end else begin
               bus.if_req = 1'b0;
            end
         end
      end
   end

   initial begin : d_requester
      exp_t e;
      op_t  op;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.d_be    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.d_req = 1'b0;
            d_q.delete();
         end else if (bus.d_ack || !bus.d_req) begin
            if (d_ops.size() > 0) begin
               op          = d_ops.pop_front();
               bus.d_req   = 1'b1;
               bus.d_we    = op.we;
               bus.d_addr  = op.addr;
               bus.d_wdata = op.wdata;
               bus.d_be    = op.be;
               d_req_cyc   = cyc;
               e.addr      = op.addr;
               e.we        = op.we;
               e.be        = op.we ? op.be : '1;
               e.wdata     = op.wdata;
               e.chk_wdata = op.we;
               e.rdata     = (op.we || !mem_en) ? '0 : mem_word(op.addr);
               e.err       = !mem_en;
               d_q.push_back(e);
            end else begin
               bus.d_req = 1'b0;
            end
         end
      end
   end

   // Memory: acks mem_delay cycles after mem_req rises; stray_cnt requests an unsolicited pulse.
   initial begin : responder
      int wait_cnt;
      int stray_done;
      bit sent;
      wait_cnt      = 0;
      stray_done    = 0;
      sent          = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.mem_ack = 1'b0;
         if (stray_done != stray_cnt) begin
            stray_done++;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hBAD0_BAD0;
         end else if (!bus.mem_req) begin
            wait_cnt = 0;
            sent     = 1'b0;
         end else if (mem_en && !sent) begin
            if (wait_cnt == mem_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               sent          = 1'b1;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t          e;
      logic          side_d;
      logic          have;
      logic [DW-1:0] rd;
      if (bus.mem_req && !mreq_prev) begin
         grant_cyc  = cyc;
         last_grant = '{addr: bus.mem_addr, we: bus.mem_we, be: bus.mem_be, wdata: bus.mem_wdata};
      end
      mreq_prev = bus.mem_req;
      if (bus.mem_ack) mack_cyc = cyc;
      if (bus.if_ack || bus.d_ack) begin
         checks++;
         if (bus.if_ack && bus.d_ack) begin
            failures++;
            $display("FAIL both_acks got if_ack=1 d_ack=1 exp one");
         end
         side_d = bus.d_ack;
         ack_log.push_back('{is_d: side_d, cyc: cyc});
         rd   = side_d ? bus.d_rdata : bus.if_rdata;
         have = side_d ? (d_q.size() > 0) : (if_q.size() > 0);
         checks++;
         if (!have) begin
            failures++;
            $display("FAIL sb_unexpected_ack side_d=%0d cyc=%0d exp none", side_d, cyc);
         end else begin
            if (side_d) e = d_q.pop_front();
            else e = if_q.pop_front();
            checks += 5;
            if (rd !== e.rdata) begin
               failures++;
               $display("FAIL sb_rdata side_d=%0d got=%h exp=%h", side_d, rd, e.rdata);
            end
            if (bus.bus_err !== e.err) begin
               failures++;
               $display("FAIL sb_bus_err side_d=%0d got=%b exp=%b", side_d, bus.bus_err, e.err);
            end
            if (last_grant.addr !== e.addr) begin
               failures++;
               $display("FAIL sb_mem_addr got=%h exp=%h", last_grant.addr, e.addr);
            end
            if (last_grant.we !== e.we) begin
               failures++;
               $display("FAIL sb_mem_we got=%b exp=%b", last_grant.we, e.we);
            end
            if (last_grant.be !== e.be) begin
               failures++;
               $display("FAIL sb_mem_be got=%b exp=%b", last_grant.be, e.be);
            end
            if (e.chk_wdata) begin
               checks++;
               if (last_grant.wdata !== e.wdata) begin
                  failures++;
                  $display("FAIL sb_mem_wdata got=%h exp=%h", last_grant.wdata, e.wdata);
               end
            end
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((if_ops.size() + d_ops.size() + if_q.size() + d_q.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout got pending=%0d exp 0",
                  if_ops.size() + d_ops.size() + if_q.size() + d_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 3;
      if ({bus.mem_req, bus.if_ack, bus.d_ack, bus.bus_err, bus.mem_we} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000",
                  {bus.mem_req, bus.if_ack, bus.d_ack, bus.bus_err, bus.mem_we});
      end
      if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_payload got=%h/%h/%h exp 0", bus.mem_addr, bus.mem_be, bus.mem_wdata);
      end
      if ({bus.if_rdata, bus.d_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_rdata got=%h/%h exp 0", bus.if_rdata, bus.d_rdata);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_if_only();
      ack_log.delete();
      fixed_en  = 1'b1;
      fixed_val = 32'h0050_0513;
      @(posedge clk);
      #1 if_ops.push_back(16'h0004);
      wait_drain(50);
      fixed_en = 1'b0;
      checks += 2;
      if (ack_log.size() != 1 || ack_log[0].is_d !== 1'b0) begin
         failures++;
         $display("FAIL if_only_acks got count=%0d exp 1 if_ack", ack_log.size());
      end else if (grant_cyc != if_req_cyc + 1 || ack_log[0].cyc != if_req_cyc + 2) begin
         failures++;
         $display("FAIL if_only_latency got req=%0d grant=%0d ack=%0d exp grant=req+1 ack=req+2",
                  if_req_cyc, grant_cyc, ack_log[0].cyc);
      end
      if (bus.if_rdata !== 32'h0050_0513) begin
         failures++;
         $display("FAIL if_rdata_hold got=%h exp=00500513", bus.if_rdata);
      end
   endtask

   task automatic test_data_priority();
      ack_log.delete();
      @(posedge clk);
      #1;
      if_ops.push_back(16'h0010);
      d_ops.push_back('{addr: 16'h0100, we: 1'b0, be: 4'h0, wdata: 32'h1234_5678});
      wait_drain(50);
      checks++;
      if (ack_log.size() != 2 || ack_log[0].is_d !== 1'b1 || ack_log[1].is_d !== 1'b0 ||
          ack_log[1].cyc != ack_log[0].cyc + 3) begin
         failures++;
         $display("FAIL priority_order got count=%0d exp D then IF 3 cycles apart", ack_log.size());
      end
   endtask

   task automatic test_streak_fairness();
      logic [12:0] exp_order;
      exp_order = 13'b1111011110110;
      ack_log.delete();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if_ops.push_back(16'h0020 + 16'(4 * i));
      for (int i = 0; i < 10; i++) begin
         d_ops.push_back('{addr: 16'h0200 + 16'(4 * i), we: 1'b0, be: 4'hF, wdata: '0});
      end
      wait_drain(300);
      checks++;
      if (ack_log.size() != 13) begin
         failures++;
         $display("FAIL streak_count got=%0d exp=13", ack_log.size());
      end else begin
         for (int i = 0; i < 13; i++) begin
            checks++;
            if (ack_log[i].is_d !== exp_order[12-i]) begin
               failures++;
               $display("FAIL streak_order idx=%0d got is_d=%b exp=%b", i, ack_log[i].is_d,
                        exp_order[12-i]);
            end
         end
      end
   endtask

   task automatic test_store_wait();
      ack_log.delete();
      mem_delay = 3;
      @(posedge clk);
      #1 d_ops.push_back('{addr: 16'h0300, we: 1'b1, be: 4'b0011, wdata: 32'hDEAD_BEEF});
      wait_drain(50);
      mem_delay = 0;
      checks += 2;
      if (ack_log.size() != 1 || ack_log[0].is_d !== 1'b1) begin
         failures++;
         $display("FAIL store_acks got count=%0d exp 1 d_ack", ack_log.size());
      end else if (mack_cyc != grant_cyc + 3 || ack_log[0].cyc != mack_cyc + 1) begin
         failures++;
         $display("FAIL store_latency got grant=%0d mem_ack=%0d d_ack=%0d exp +3 then +1",
                  grant_cyc, mack_cyc, ack_log[0].cyc);
      end
      if (bus.d_rdata !== '0) begin
         failures++;
         $display("FAIL store_rdata_hold got=%h exp=0", bus.d_rdata);
      end
   endtask

   task automatic test_timeout_stray();
      ack_log.delete();
      mem_en = 1'b0;
      @(posedge clk);
      #1 if_ops.push_back(16'h0040);
      wait_drain(60);
      mem_en = 1'b1;
      checks++;
      if (ack_log.size() != 1 || ack_log[0].cyc != if_req_cyc + Timeout + 1) begin
         failures++;
         $display("FAIL timeout_latency got count=%0d ack=%0d exp ack=%0d", ack_log.size(),
                  (ack_log.size() > 0) ? ack_log[0].cyc : -1, if_req_cyc + Timeout + 1);
      end
      ack_log.delete();
      stray_cnt++;
      repeat (4) @(negedge clk);
      checks++;
      if (ack_log.size() != 0 || bus.mem_req !== 1'b0 || bus.if_rdata !== '0 ||
          bus.bus_err !== 1'b0) begin
         failures++;
         $display("FAIL stray_ack got acks=%0d mem_req=%b if_rdata=%h exp no change",
                  ack_log.size(), bus.mem_req, bus.if_rdata);
      end
      @(posedge clk);
      #1 if_ops.push_back(16'h0044);
      wait_drain(50);
      checks++;
      if (ack_log.size() != 1 || ack_log[0].cyc != if_req_cyc + 2) begin
         failures++;
         $display("FAIL after_stray got count=%0d exp 1 ack at req+2", ack_log.size());
      end
   endtask

   task automatic test_reset_busy();
      int n;
      int seen;
      ack_log.delete();
      mem_en = 1'b0;
      @(posedge clk);
      #1 if_ops.push_back(16'h0080);
      n = 0;
      while (bus.mem_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 10) begin
         failures++;
         $display("FAIL rst_busy_grant got mem_req=%b exp 1", bus.mem_req);
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.if_ack, bus.d_ack, bus.bus_err} !== 4'b0) begin
         failures++;
         $display("FAIL rst_busy_outputs got=%b exp=0000",
                  {bus.mem_req, bus.if_ack, bus.d_ack, bus.bus_err});
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.mem_req || bus.if_ack || bus.d_ack) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL rst_busy_dropped got activity=%0d exp=0", seen);
      end
      mem_en = 1'b1;
      ack_log.delete();
      @(posedge clk);
      #1 if_ops.push_back(16'h0084);
      wait_drain(50);
      checks++;
      if (ack_log.size() != 1 || ack_log[0].cyc != if_req_cyc + 2) begin
         failures++;
         $display("FAIL rst_busy_recover got count=%0d exp 1 ack at req+2", ack_log.size());
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_if_only();
      test_data_priority();
      test_streak_fairness();
      test_store_wait();
      test_timeout_stray();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
